// File: rtl/lisnoc_usb_from_noc_mc_if.sv
// Bus bundle for lisnoc_usb_from_noc_mc: the per-channel NoC input side and
// the USB word output side. The packetiser connects through the slave
// modport; whatever feeds flits and drains USB words uses the master modport.
interface lisnoc_usb_from_noc_mc_if #(
    parameter int FLIT_DATA_WIDTH = 16,
    parameter int VCHANNELS       = 2
);
    logic [FLIT_DATA_WIDTH-1:0]                 out_usb_data;
    logic                                       out_usb_valid;
    logic                                       out_usb_ready;
    logic [VCHANNELS*(FLIT_DATA_WIDTH+2)-1:0]   in_noc_data;
    logic [VCHANNELS-1:0]                       in_noc_valid;
    logic [VCHANNELS-1:0]                       in_noc_ready;

    modport master (
        output in_noc_data, in_noc_valid, out_usb_ready,
        input  in_noc_ready, out_usb_data, out_usb_valid
    );

    modport slave (
        input  in_noc_data, in_noc_valid, out_usb_ready,
        output in_noc_ready, out_usb_data, out_usb_valid
    );
endinterface

// File: rtl/lisnoc_usb_from_noc_mc.sv
// Multi-channel NoC-to-USB packetiser. Each NoC channel is buffered
// store-and-forward; complete packets are granted round-robin and emitted as
// one header word (channel index in the top 3 bits, flit count in the low
// bits) followed by the flit payloads. The stream is padded with zero words
// to the next BULK_LENGTH boundary when a flush is requested.
// Optional feature: define LISNOC_USB_FLUSH_TIMER_EN to add the idle timer
// that requests a flush after MAX_TIMEOUT idle cycles with a partial bulk.
module lisnoc_usb_from_noc_mc #(
    parameter int FLIT_DATA_WIDTH = 16,
    parameter int VCHANNELS       = 2,
    parameter int FIFO_DEPTH      = 32,
    parameter int BULK_LENGTH     = 256,
    parameter int MAX_TIMEOUT     = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_manual,
    lisnoc_usb_from_noc_mc_if.slave bus
);
    localparam int FW   = FLIT_DATA_WIDTH;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int CH_W = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;
    localparam int WC_W = $clog2(BULK_LENGTH);

    typedef enum logic [1:0] {IDLE, HEADER, PUSH, FLUSH} state_t;

    state_t          state, state_n;
    logic [CH_W-1:0] grant, grant_n, rr_ptr, rr_ptr_n, rr_pick;
    logic [WC_W-1:0] word_count;
    logic            flush_pend, flush_pend_n;
    logic            any_pkt, usb_valid, xfer;
    logic [FW-1:0]   usb_data, hdr_word;
    logic [VCHANNELS-1:0] pkt_avail, full;
    logic [FW+1:0]   head_flit [VCHANNELS];
    logic [LW-1:0]   head_len  [VCHANNELS];
    logic [FW+1:0]   cur_flit;
    logic [LW-1:0]   cur_len;

`ifdef LISNOC_USB_FLUSH_TIMER_EN
    localparam int TW = $clog2(MAX_TIMEOUT) + 1;
    logic [TW-1:0] timer, timer_n;
`endif

    for (genvar c = 0; c < VCHANNELS; c++) begin : g_ch
        logic [FW+1:0] mem  [FIFO_DEPTH];
        logic [LW-1:0] lmem [FIFO_DEPTH];
        logic [AW:0]   wr_ptr, rd_ptr, lwr_ptr, lrd_ptr, pkt_cnt;
        logic [LW-1:0] len_acc;
        logic [FW+1:0] flit;
        logic          push, push_end, pop, pop_end;

        // Type bit FW+1 is set for LAST (2'b10) and SINGLE (2'b11): end of packet.
        assign flit     = bus.in_noc_data[c*(FW+2) +: (FW+2)];
        assign full[c]  = (wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH);
        assign push     = bus.in_noc_valid[c] && !full[c];
        assign push_end = push && flit[FW+1];
        assign pop      = xfer && (state == PUSH) && (grant == CH_W'(c));
        assign pop_end  = pop && head_flit[c][FW+1];

        assign head_flit[c] = mem[rd_ptr[AW-1:0]];
        assign head_len[c]  = lmem[lrd_ptr[AW-1:0]];
        assign pkt_avail[c] = (pkt_cnt != '0);

        // Flit and packet-length storage; contents need no reset.
        always_ff @(posedge clk) begin
            if (push)     mem[wr_ptr[AW-1:0]]   <= flit;
            if (push_end) lmem[lwr_ptr[AW-1:0]] <= len_acc + 1'b1;
        end

        // Buffer pointers, complete-packet count and running packet length.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                lwr_ptr <= '0;
                lrd_ptr <= '0;
                pkt_cnt <= '0;
                len_acc <= '0;
            end else begin
                if (push)     wr_ptr  <= wr_ptr + 1'b1;
                if (pop)      rd_ptr  <= rd_ptr + 1'b1;
                if (push_end) lwr_ptr <= lwr_ptr + 1'b1;
                if (pop_end)  lrd_ptr <= lrd_ptr + 1'b1;
                pkt_cnt <= pkt_cnt + (AW+1)'(push_end) - (AW+1)'(pop_end);
                if (push)     len_acc <= push_end ? '0 : len_acc + 1'b1;
            end
        end
    end

    assign bus.in_noc_ready = ~full;
    assign cur_flit = head_flit[grant];
    assign cur_len  = head_len[grant];

    // Round-robin pick: first channel holding a complete packet, starting at rr_ptr.
    always_comb begin
        int idx;
        any_pkt = 1'b0;
        rr_pick = rr_ptr;
        idx     = 0;
        for (int i = VCHANNELS - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % VCHANNELS;
            if (pkt_avail[idx[CH_W-1:0]]) begin
                any_pkt = 1'b1;
                rr_pick = idx[CH_W-1:0];
            end
        end
    end

    // Header word: channel in the top three bits, packet length in the low bits.
    always_comb begin
        hdr_word             = '0;
        hdr_word[FW-1 -: 3]  = 3'(grant);
        hdr_word[LW-1:0]     = cur_len;
    end

    // USB output word selected by the current state.
    always_comb begin
        usb_valid = 1'b0;
        usb_data  = '0;
        case (state)
            HEADER:  begin usb_valid = 1'b1; usb_data = hdr_word;         end
            PUSH:    begin usb_valid = 1'b1; usb_data = cur_flit[FW-1:0]; end
            FLUSH:   begin usb_valid = 1'b1; usb_data = '0;               end
            default: ;
        endcase
    end

    assign xfer              = usb_valid && bus.out_usb_ready;
    assign bus.out_usb_valid = usb_valid;
    assign bus.out_usb_data  = usb_data;

    // Next-state logic: flush beats a pending packet; the pointer moves past a finished packet.
    always_comb begin
        state_n      = state;
        grant_n      = grant;
        rr_ptr_n     = rr_ptr;
        flush_pend_n = flush_pend | flush_manual;
`ifdef LISNOC_USB_FLUSH_TIMER_EN
        timer_n      = xfer ? '0 : timer;
`endif
        case (state)
            IDLE: begin
                if (flush_pend && word_count != '0) begin
                    state_n      = FLUSH;
                    flush_pend_n = 1'b0;
`ifdef LISNOC_USB_FLUSH_TIMER_EN
                    timer_n      = '0;
`endif
                end else if (any_pkt) begin
                    state_n = HEADER;
                    grant_n = rr_pick;
                end
`ifdef LISNOC_USB_FLUSH_TIMER_EN
                else if (word_count != '0) begin
                    if (timer == TW'(MAX_TIMEOUT - 1)) flush_pend_n = 1'b1;
                    else                               timer_n = timer + 1'b1;
                end
`endif
                // Nothing to pad on a bulk boundary, so a request is dropped.
                if (word_count == '0) flush_pend_n = 1'b0;
            end
            HEADER: if (xfer) state_n = PUSH;
            PUSH: begin
                if (xfer && cur_flit[FW+1]) begin
                    state_n  = IDLE;
                    rr_ptr_n = (grant == CH_W'(VCHANNELS - 1)) ? '0 : grant + 1'b1;
                end
            end
            FLUSH: if (xfer && word_count == {WC_W{1'b1}}) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control registers: FSM, grant, pointer, bulk word counter, flush request, timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            word_count <= '0;
            flush_pend <= 1'b0;
`ifdef LISNOC_USB_FLUSH_TIMER_EN
            timer      <= '0;
`endif
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            rr_ptr     <= rr_ptr_n;
            flush_pend <= flush_pend_n;
            if (xfer) word_count <= word_count + 1'b1;
`ifdef LISNOC_USB_FLUSH_TIMER_EN
            timer      <= timer_n;
`endif
        end
    end
endmodule

// File: tb/tb_lisnoc_usb_from_noc_mc.sv
// Bench for lisnoc_usb_from_noc_mc: directed scenarios plus randomized packet
// loads, checked against a packet-level reference model of the USB stream.
module tb_lisnoc_usb_from_noc_mc;
    localparam int FW = 16, VC = 2, FD = 32, BL = 256, MT = 1024;

    logic clk, rst, flush_manual;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    lisnoc_usb_from_noc_mc_if #(.FLIT_DATA_WIDTH(FW), .VCHANNELS(VC)) bus ();

    lisnoc_usb_from_noc_mc #(
        .FLIT_DATA_WIDTH(FW), .VCHANNELS(VC), .FIFO_DEPTH(FD),
        .BULK_LENGTH(BL), .MAX_TIMEOUT(MT)
    ) dut (
        .clk(clk), .rst(rst), .flush_manual(flush_manual), .bus(bus)
    );

    int vectors = 0, errors = 0, rdy_mode = 0, mptr = 0;
    logic [FW-1:0] got[$], exp_q[$], pk[$];
    int            mlen[VC][$];
    logic [FW-1:0] mdat[VC][$];
    logic          prev_stall = 1'b0;
    logic [FW-1:0] prev_data  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // USB sink ready pattern: 0 low, 1 high, 2 toggle, 3 random.
    initial begin
        bus.out_usb_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0: bus.out_usb_ready = 1'b0;
                1: bus.out_usb_ready = 1'b1;
                2: bus.out_usb_ready = ~bus.out_usb_ready;
                default: bus.out_usb_ready = 1'($urandom);
            endcase
        end
    end

    // Capture transferred words; a stalled word must stay put.
    always @(negedge clk) begin
        if (rst) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.out_usb_valid), 32'd1);
                chk("hold_data", 32'(bus.out_usb_data), 32'(prev_data));
            end
            if (bus.out_usb_valid && bus.out_usb_ready) got.push_back(bus.out_usb_data);
            prev_stall = bus.out_usb_valid && !bus.out_usb_ready;
            prev_data  = bus.out_usb_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1; flush_manual = 1'b0;
        bus.in_noc_valid = '0; bus.in_noc_data = '0; rdy_mode = 0;
        tick(3);
        rst = 1'b0;
        got.delete(); exp_q.delete(); mptr = 0;
        for (int c = 0; c < VC; c++) begin mlen[c].delete(); mdat[c].delete(); end
    endtask

    task automatic push_flit(input int ch, input logic [1:0] t, input logic [FW-1:0] d, output bit ok);
        int   guard;
        logic r;
        guard = 0; ok = 1'b0;
        bus.in_noc_data[ch*(FW+2) +: (FW+2)] = {t, d};
        bus.in_noc_valid[ch] = 1'b1;
        while (!ok && guard < 200) begin
            @(negedge clk); r = bus.in_noc_ready[ch];
            @(posedge clk); #1;
            guard++;
            if (r) ok = 1'b1;
        end
        bus.in_noc_valid[ch] = 1'b0;
    endtask

    // Send the flits in pk on channel ch and record the packet in the model.
    task automatic send_pkt(input int ch);
        int n; bit ok; logic [1:0] t;
        n = pk.size();
        for (int i = 0; i < n; i++) begin
            if (n == 1)          t = 2'b11;
            else if (i == 0)     t = 2'b01;
            else if (i == n - 1) t = 2'b10;
            else                 t = 2'b00;
            push_flit(ch, t, pk[i], ok);
            chk("push_ok", 32'(ok), 32'd1);
        end
        mlen[ch].push_back(n);
        foreach (pk[i]) mdat[ch].push_back(pk[i]);
    endtask

    task automatic rand_pk(input int n);
        pk.delete();
        repeat (n) pk.push_back(FW'($urandom));
    endtask

    function automatic logic [FW-1:0] hdr(input int c, input int n);
        return FW'(c * (1 << (FW - 3)) + n);
    endfunction

    // Reference: serve recorded packets round-robin, one whole packet per grant.
    task automatic model_sched();
        int c, n;
        forever begin
            c = -1;
            for (int k = 0; k < VC && c < 0; k++)
                if (mlen[(mptr + k) % VC].size() > 0) c = (mptr + k) % VC;
            if (c < 0) break;
            n = mlen[c].pop_front();
            exp_q.push_back(hdr(c, n));
            repeat (n) exp_q.push_back(mdat[c].pop_front());
            mptr = (c + 1) % VC;
        end
    endtask

    task automatic pad(input int n);
        repeat (n) exp_q.push_back('0);
    endtask

    task automatic wait_words(input int n, input int budget);
        int cyc;
        cyc = 0;
        while (got.size() < n && cyc < budget) begin tick(1); cyc++; end
        tick(10);
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({tag, "_word"}, 32'(got[i]), 32'(exp_q[i]));
        got.delete(); exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, n0;
        // Reset values.
        rst = 1'b1; flush_manual = 1'b0; bus.in_noc_valid = '0; bus.in_noc_data = '0;
        tick(2);
        chk("rst_valid", 32'(bus.out_usb_valid), 32'd0);
        chk("rst_data",  32'(bus.out_usb_data),  32'd0);
        chk("rst_ready", 32'(bus.in_noc_ready),  32'd3);
        do_reset();

        // Single-flit packet on channel 1.
        rdy_mode = 1;
        pk = '{16'h1234};
        send_pkt(1);
        wait_words(2, 100);
        chk("t1_hdr", 32'(got[0]), 32'h2001);
        model_sched();
        compare_stream("t1");

        // Three flits on channel 0 with a toggling sink.
        do_reset();
        rdy_mode = 2;
        pk = '{16'h000A, 16'h000B, 16'h000C};
        send_pkt(0);
        wait_words(4, 100);
        chk("t2_hdr", 32'(got[0]), 32'h0003);
        model_sched();
        compare_stream("t2");

        // Two packets pending on each channel: strict alternation.
        do_reset();
        rand_pk(2); send_pkt(0);
        rand_pk(1); send_pkt(1);
        rand_pk(3); send_pkt(0);
        rand_pk(2); send_pkt(1);
        rdy_mode = 1;
        wait_words(12, 200);
        model_sched();
        compare_stream("t3_rr");

        // Randomized loads with a random sink.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            n0 = 0;
            for (int c = 0; c < VC; c++) begin
                int np;
                np = (c == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 4));
                repeat (np) begin rand_pk(int'($urandom_range(1, 8))); send_pkt(c); end
            end
            model_sched();
            n0 = exp_q.size();
            rdy_mode = 3;
            wait_words(n0, 2000);
            compare_stream("rand");
        end

        // Manual flush during a 4-flit packet: packet intact, then padding.
        do_reset();
        rand_pk(4); send_pkt(0);
        rdy_mode = 2;
        gap = 0;
        while (got.size() < 2 && gap < 100) begin tick(1); gap++; end
        flush_manual = 1'b1; tick(1); flush_manual = 1'b0;
        wait_words(BL, 2000);
        model_sched();
        pad(BL - 5);
        compare_stream("t5_flush");

        // Five words then idle.
        do_reset();
        rdy_mode = 1;
        rand_pk(4); send_pkt(0);
        gap = 0;
        while (got.size() < 5 && gap < 100) begin tick(1); gap++; end
        model_sched();
        pad(BL - 5);
`ifdef LISNOC_USB_FLUSH_TIMER_EN
        gap = 0;
        while (!bus.out_usb_valid && gap < MT + 100) begin tick(1); gap++; end
        chk("timeout_gap_ok", 32'(gap >= MT && gap <= MT + 4), 32'd1);
        wait_words(BL, 600);
        compare_stream("t4_timeout");
`else
        tick(MT + 50);
        chk("no_auto_flush", 32'(got.size()), 32'd5);
        flush_manual = 1'b1; tick(1); flush_manual = 1'b0;
        wait_words(BL, 600);
        compare_stream("t4_manual");
`endif
        // Bulk boundary reached: a further flush has nothing to pad.
        flush_manual = 1'b1; tick(1); flush_manual = 1'b0;
        tick(30);
        chk("boundary_noflush", 32'(got.size()), 32'd0);

        // Fill channel 0, channel 1 still accepts, then reset mid-transfer.
        do_reset();
        rand_pk(FD); send_pkt(0);
        chk("full_ready0", 32'(bus.in_noc_ready[0]), 32'd0);
        chk("full_ready1", 32'(bus.in_noc_ready[1]), 32'd1);
        rand_pk(1); send_pkt(1);
        rdy_mode = 1;
        gap = 0;
        while (got.size() < 5 && gap < 100) begin tick(1); gap++; end
        chk("fill_hdr", 32'(got[0]), 32'(hdr(0, FD)));
        rst = 1'b1;
        tick(1);
        chk("midrst_valid", 32'(bus.out_usb_valid), 32'd0);
        chk("midrst_data",  32'(bus.out_usb_data),  32'd0);
        chk("midrst_ready", 32'(bus.in_noc_ready),  32'd3);
        rst = 1'b0;
        got.delete();
        tick(50);
        chk("discarded", 32'(got.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
